// File: rtl/loop_issue_scheduler_pkg.sv
// Shared types and helpers for the loop issue scheduler.
package loop_sched_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Default initiation interval when no override is given.
    localparam int II_DEFAULT = 1;

    // Phase counter width for a given initiation interval. The extra bit keeps
    // II=1 at a legal one-bit width and leaves headroom at powers of two.
    function automatic int phase_width(input int ii);
        return $clog2(ii) + 1;
    endfunction

    // Phase counter width for the default initiation interval.
    localparam int PH_W = phase_width(II_DEFAULT);

endpackage

// File: rtl/loop_issue_scheduler_phase.sv
// Modulo-II phase counter. Holds while en is low, returns to zero on clear,
// and flags the issue slot with at_zero.
module ii_phase_counter
    import loop_sched_pkg::*;
#(
    parameter int II   = II_DEFAULT,
    parameter int PH_W = phase_width(II)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic at_zero
);

    localparam logic [PH_W-1:0] LAST = PH_W'(II - 1);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    // Next phase: clear wins, otherwise advance and wrap at II-1 when enabled.
    always_comb begin
        // NOTE: default assigned first so every path drives phase_d; no latch.
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign at_zero = (phase_q == '0);

endmodule

// File: rtl/loop_issue_scheduler.sv
// Loop issue scheduler: after start, emits one happening pulse every II
// unstalled cycles for trip_count iterations, tags each with its index, flags
// the last one and pulses done once the final issue has gone out.
module loop_issue_scheduler
    import loop_sched_pkg::*;
#(
    parameter int II   = 1,
    parameter int TC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TC_W-1:0] trip_count,
    input  logic            stall,
    output logic            happening,
    output logic [TC_W-1:0] iter,
    output logic            x_at_trip_count,
    output logic            busy,
    output logic            done
);

    localparam int LOCAL_PH_W = phase_width(II);

    state_e          state_q, state_d;
    logic [TC_W-1:0] iter_q, iter_d;
    logic [TC_W-1:0] tc_q, tc_d;
    logic            in_run;
    logic            at_zero;
    logic            last_iter;

    assign in_run    = (state_q == RUN);
    // tc_q is never zero in RUN, so tc_q-1 cannot underflow where it matters.
    assign last_iter = (iter_q == tc_q - TC_W'(1));

    // Phase only advances in unstalled RUN cycles and is parked at zero
    // outside RUN, so the first issue lands right after start is accepted.
    ii_phase_counter #(
        .II   (II),
        .PH_W (LOCAL_PH_W)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_run),
        .en      (in_run && !stall),
        .at_zero (at_zero)
    );

    assign happening       = in_run && at_zero && !stall;
    assign x_at_trip_count = happening && last_iter;
    assign iter            = iter_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);

    // Next-state logic: launch, per-issue iteration advance and completion.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        tc_d    = tc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    iter_d = '0;
                    if (trip_count != '0) begin
                        tc_d    = trip_count;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (happening) begin
                    if (last_iter) begin
                        state_d = FIN;
                    end else begin
                        iter_d = iter_q + TC_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, iteration and trip-count registers; reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            tc_q    <= tc_d;
        end
    end

endmodule

// File: tb/tb_loop_issue_scheduler.sv
// Directed bench for loop_issue_scheduler. Four instances share stimulus:
// [0] II=3, [1] II=1, [2] II=2 (all TC_W=16) and [3] II=1 with TC_W=4 for the
// full-range trip count. Each cycle's outputs are logged into per-instance
// bit masks indexed by cycle number (cycle 0 = the cycle start is driven).
module tb_loop_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [15:0] trip_count;

    logic [3:0]  hap, xat, done, busy;
    logic [15:0] iter0, iter1, iter2;
    logic [3:0]  iter3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] hap_m  [4];
    logic [63:0] x_m    [4];
    logic [63:0] done_m [4];
    logic [63:0] busy_m [4];
    logic [15:0] iter_log [4][64];

    always #5 clk = ~clk;

    loop_issue_scheduler #(.II(3), .TC_W(16)) u_ii3 (
        .clk(clk), .rst(rst), .start(start), .trip_count(trip_count), .stall(stall),
        .happening(hap[0]), .iter(iter0), .x_at_trip_count(xat[0]), .busy(busy[0]), .done(done[0])
    );
    loop_issue_scheduler #(.II(1), .TC_W(16)) u_ii1 (
        .clk(clk), .rst(rst), .start(start), .trip_count(trip_count), .stall(stall),
        .happening(hap[1]), .iter(iter1), .x_at_trip_count(xat[1]), .busy(busy[1]), .done(done[1])
    );
    loop_issue_scheduler #(.II(2), .TC_W(16)) u_ii2 (
        .clk(clk), .rst(rst), .start(start), .trip_count(trip_count), .stall(stall),
        .happening(hap[2]), .iter(iter2), .x_at_trip_count(xat[2]), .busy(busy[2]), .done(done[2])
    );
    loop_issue_scheduler #(.II(1), .TC_W(4)) u_tc4 (
        .clk(clk), .rst(rst), .start(start), .trip_count(trip_count[3:0]), .stall(stall),
        .happening(hap[3]), .iter(iter3), .x_at_trip_count(xat[3]), .busy(busy[3]), .done(done[3])
    );

    // One clock cycle: drive inputs after the edge, sample at the falling edge.
    task automatic cycle(input logic st, input logic sl, input logic r);
        start = st;
        stall = sl;
        rst   = r;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            hap_m[i][cyc]  = hap[i];
            x_m[i][cyc]    = xat[i];
            done_m[i][cyc] = done[i];
            busy_m[i][cyc] = busy[i];
        end
        iter_log[0][cyc] = iter0;
        iter_log[1][cyc] = iter1;
        iter_log[2][cyc] = iter2;
        iter_log[3][cyc] = {12'd0, iter3};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        trip_count = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hap_m[i]  = '0;
            x_m[i]    = '0;
            done_m[i] = '0;
            busy_m[i] = '0;
        end
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (hap !== 4'b0)  begin errors++; $display("FAIL reset_happening: got %b expected 0000", hap); end
        checks++; if (xat !== 4'b0)  begin errors++; $display("FAIL reset_x_at_tc: got %b expected 0000", xat); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        checks++; if (iter0 !== 16'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", iter0); end
        @(posedge clk);
        #1;
    endtask

    // II=3, trip 4: issues at t1,t4,t7,t10, last at t10, done t11, busy t1..t11.
    task automatic test_basic();
        int hc [4] = '{1, 4, 7, 10};
        do_reset();
        trip_count = 16'd4;
        cycle(1'b1, 1'b0, 1'b0);
        idle(13);
        checks++; if (hap_m[0] !== 64'h492)  begin errors++; $display("FAIL basic_happening: got %h expected %h", hap_m[0], 64'h492); end
        checks++; if (x_m[0] !== 64'h400)    begin errors++; $display("FAIL basic_x_at_tc: got %h expected %h", x_m[0], 64'h400); end
        checks++; if (done_m[0] !== 64'h800) begin errors++; $display("FAIL basic_done: got %h expected %h", done_m[0], 64'h800); end
        checks++; if (busy_m[0] !== 64'hFFE) begin errors++; $display("FAIL basic_busy: got %h expected %h", busy_m[0], 64'hFFE); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (iter_log[0][hc[k]] !== 16'(k)) begin
                errors++;
                $display("FAIL basic_iter@t%0d: got %0d expected %0d", hc[k], iter_log[0][hc[k]], k);
            end
        end
    endtask

    // II=1, trip 5: contiguous issues t1..t5, done t6.
    task automatic test_ii1();
        do_reset();
        trip_count = 16'd5;
        cycle(1'b1, 1'b0, 1'b0);
        idle(8);
        checks++; if (hap_m[1] !== 64'h3E)  begin errors++; $display("FAIL ii1_happening: got %h expected %h", hap_m[1], 64'h3E); end
        checks++; if (x_m[1] !== 64'h20)    begin errors++; $display("FAIL ii1_x_at_tc: got %h expected %h", x_m[1], 64'h20); end
        checks++; if (done_m[1] !== 64'h40) begin errors++; $display("FAIL ii1_done: got %h expected %h", done_m[1], 64'h40); end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (iter_log[1][k] !== 16'(k - 1)) begin
                errors++;
                $display("FAIL ii1_iter@t%0d: got %0d expected %0d", k, iter_log[1][k], k - 1);
            end
        end
    endtask

    // trip 0: no issue, done (and busy) only at t1.
    task automatic test_zero_trip();
        do_reset();
        trip_count = 16'd0;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        checks++; if (hap_m[0] !== 64'h0)  begin errors++; $display("FAIL zero_happening_ii3: got %h expected 0", hap_m[0]); end
        checks++; if (hap_m[1] !== 64'h0)  begin errors++; $display("FAIL zero_happening_ii1: got %h expected 0", hap_m[1]); end
        checks++; if (done_m[0] !== 64'h2) begin errors++; $display("FAIL zero_done: got %h expected %h", done_m[0], 64'h2); end
        checks++; if (busy_m[0] !== 64'h2) begin errors++; $display("FAIL zero_busy: got %h expected %h", busy_m[0], 64'h2); end
    endtask

    // trip 3, stall held for cycles t2 and t3.
    // II=2: issues t1,t5,t7, done t8.  II=3: t1,t6,t9, done t10.
    // II=1: t1,t4,t5, done t6 (stall suppresses the t2/t3 issue slots).
    task automatic test_stall();
        int sc [3] = '{1, 5, 7};
        do_reset();
        trip_count = 16'd3;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(8);
        checks++; if (hap_m[2] !== 64'hA2)   begin errors++; $display("FAIL stall_happening_ii2: got %h expected %h", hap_m[2], 64'hA2); end
        checks++; if (x_m[2] !== 64'h80)     begin errors++; $display("FAIL stall_x_at_tc_ii2: got %h expected %h", x_m[2], 64'h80); end
        checks++; if (done_m[2] !== 64'h100) begin errors++; $display("FAIL stall_done_ii2: got %h expected %h", done_m[2], 64'h100); end
        checks++; if (busy_m[2] !== 64'h1FE) begin errors++; $display("FAIL stall_busy_ii2: got %h expected %h", busy_m[2], 64'h1FE); end
        checks++; if (hap_m[0] !== 64'h242)  begin errors++; $display("FAIL stall_happening_ii3: got %h expected %h", hap_m[0], 64'h242); end
        checks++; if (done_m[0] !== 64'h400) begin errors++; $display("FAIL stall_done_ii3: got %h expected %h", done_m[0], 64'h400); end
        checks++; if (hap_m[1] !== 64'h32)   begin errors++; $display("FAIL stall_happening_ii1: got %h expected %h", hap_m[1], 64'h32); end
        checks++; if (done_m[1] !== 64'h40)  begin errors++; $display("FAIL stall_done_ii1: got %h expected %h", done_m[1], 64'h40); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (iter_log[2][sc[k]] !== 16'(k)) begin
                errors++;
                $display("FAIL stall_iter@t%0d: got %0d expected %0d", sc[k], iter_log[2][sc[k]], k);
            end
        end
    endtask

    // II=3, trip 4; start with trip 9 at t2 is ignored. Start at t12 (the
    // cycle after FIN) with trip 1 is accepted: issue t13, done t14.
    task automatic test_restart_ignored();
        do_reset();
        trip_count = 16'd4;
        cycle(1'b1, 1'b0, 1'b0);
        idle(1);
        trip_count = 16'd9;
        cycle(1'b1, 1'b0, 1'b0);
        idle(9);
        trip_count = 16'd1;
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        checks++; if (hap_m[0] !== 64'h2492)  begin errors++; $display("FAIL restart_happening: got %h expected %h", hap_m[0], 64'h2492); end
        checks++; if (x_m[0] !== 64'h2400)    begin errors++; $display("FAIL restart_x_at_tc: got %h expected %h", x_m[0], 64'h2400); end
        checks++; if (done_m[0] !== 64'h4800) begin errors++; $display("FAIL restart_done: got %h expected %h", done_m[0], 64'h4800); end
        checks++; if (busy_m[0] !== 64'h6FFE) begin errors++; $display("FAIL restart_busy: got %h expected %h", busy_m[0], 64'h6FFE); end
        checks++; if (iter_log[0][13] !== 16'd0) begin errors++; $display("FAIL restart_iter@t13: got %0d expected 0", iter_log[0][13]); end
    endtask

    // II=3, trip 4, rst during t5: outputs clear at t6, no done. New start
    // at t8 with trip 2: issues t9 (iter 0), t12 (iter 1), done t13.
    task automatic test_reset_midrun();
        do_reset();
        trip_count = 16'd4;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1);
        idle(2);
        trip_count = 16'd2;
        cycle(1'b1, 1'b0, 1'b0);
        idle(8);
        checks++; if (hap_m[0] !== 64'h1212)  begin errors++; $display("FAIL midrst_happening: got %h expected %h", hap_m[0], 64'h1212); end
        checks++; if (done_m[0] !== 64'h2000) begin errors++; $display("FAIL midrst_done: got %h expected %h", done_m[0], 64'h2000); end
        checks++; if (busy_m[0] !== 64'h3E3E) begin errors++; $display("FAIL midrst_busy: got %h expected %h", busy_m[0], 64'h3E3E); end
        checks++; if (x_m[0] !== 64'h1000)    begin errors++; $display("FAIL midrst_x_at_tc: got %h expected %h", x_m[0], 64'h1000); end
        checks++; if (iter_log[0][6] !== 16'd0)  begin errors++; $display("FAIL midrst_iter@t6: got %0d expected 0", iter_log[0][6]); end
        checks++; if (iter_log[0][9] !== 16'd0)  begin errors++; $display("FAIL midrst_iter@t9: got %0d expected 0", iter_log[0][9]); end
        checks++; if (iter_log[0][12] !== 16'd1) begin errors++; $display("FAIL midrst_iter@t12: got %0d expected 1", iter_log[0][12]); end
    endtask

    // TC_W=4, II=1, trip 15 (all ones): 15 issues t1..t15, last iter 14 at
    // t15 without wrap, done t16.
    task automatic test_max_trip();
        do_reset();
        trip_count = 16'h000F;
        cycle(1'b1, 1'b0, 1'b0);
        idle(18);
        checks++; if (hap_m[3] !== 64'hFFFE)   begin errors++; $display("FAIL max_happening: got %h expected %h", hap_m[3], 64'hFFFE); end
        checks++; if (x_m[3] !== 64'h8000)     begin errors++; $display("FAIL max_x_at_tc: got %h expected %h", x_m[3], 64'h8000); end
        checks++; if (done_m[3] !== 64'h10000) begin errors++; $display("FAIL max_done: got %h expected %h", done_m[3], 64'h10000); end
        checks++; if (iter_log[3][1] !== 16'd0)   begin errors++; $display("FAIL max_iter@t1: got %0d expected 0", iter_log[3][1]); end
        checks++; if (iter_log[3][15] !== 16'd14) begin errors++; $display("FAIL max_iter@t15: got %0d expected 14", iter_log[3][15]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ii1();
        test_zero_trip();
        test_stall();
        test_restart_ignored();
        test_reset_midrun();
        test_max_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
